// File: rtl/mkio_pkg.sv
`default_nettype none
// ============================================================================
// mkio_pkg : shared constants, command-word fields, FSM state type and the
//            Manchester word encoder for the MIL-STD-1553B BC transmitter.
// Revision : 1.0
// ============================================================================
package mkio_pkg;

  localparam logic [5:0] SYNC_CMD  = 6'b111000;
  localparam logic [5:0] SYNC_DATA = 6'b000111;

  localparam int RTA_MSB = 15;
  localparam int RTA_LSB = 11;
  localparam int TR_BIT  = 10;
  localparam int SA_MSB  = 9;
  localparam int SA_LSB  = 5;
  localparam int WC_MSB  = 4;
  localparam int WC_LSB  = 0;

  localparam int WORD_HALF_BITS = 40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_BITS   = 3'd2,
    ST_PARITY = 3'd3,
    ST_END    = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  // Half-bit image of one word, MSB transmitted first: sync, 16 bit-pairs, parity pair.
  function automatic logic [WORD_HALF_BITS-1:0] encode_word(input logic [5:0]  sync,
                                                            input logic [15:0] data);
    logic [WORD_HALF_BITS-1:0] w;
    logic                      p;
    w        = '0;
    w[39:34] = sync;
    for (int i = 0; i < 16; i++) begin
      w[33 - 2*(15 - i)] = data[i];
      w[32 - 2*(15 - i)] = ~data[i];
    end
    p    = ~^data;
    w[1] = p;
    w[0] = ~p;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mkio_manchester_ser.sv
`default_nettype none
// ============================================================================
// mkio_manchester_ser : half-bit timer and 40-half-bit shift register.
//                       load restarts the timer so words abut without a gap.
// Revision : 1.0
// ============================================================================
module mkio_manchester_ser
  import mkio_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  logic                      load_i,
  input  logic [WORD_HALF_BITS-1:0] word_i,
  output logic                      line_o,
  output logic [5:0]                half_idx_o,
  output logic                      half_tick_o,
  output logic                      word_end_o
);

  localparam int TW = (CLK_PER_HALF_BIT > 1) ? $clog2(CLK_PER_HALF_BIT) : 1;

  logic [TW-1:0]             tmr_q;
  logic [5:0]                hb_q;
  logic [WORD_HALF_BITS-1:0] sh_q;

  assign half_tick_o = en_i && (tmr_q == TW'(CLK_PER_HALF_BIT - 1));
  assign word_end_o  = half_tick_o && (hb_q == 6'(WORD_HALF_BITS - 1));
  assign line_o      = sh_q[WORD_HALF_BITS-1];
  assign half_idx_o  = hb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
      hb_q  <= '0;
      sh_q  <= '0;
    end else if (load_i) begin
      tmr_q <= '0;
      hb_q  <= '0;
      sh_q  <= word_i;
    end else if (en_i) begin
      if (half_tick_o) begin
        tmr_q <= '0;
        sh_q  <= {sh_q[WORD_HALF_BITS-2:0], 1'b0};
        hb_q  <= (hb_q == 6'(WORD_HALF_BITS - 1)) ? 6'd0 : hb_q + 6'd1;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mkio_bc_tx.sv
`default_nettype none
// ============================================================================
// mkio_bc_tx : MIL-STD-1553B bus-controller BC->RT message transmitter.
//              Optional MKIO_BC_MIN_GAP_EN keeps busy high for GAP_CLKS after done.
// Revision   : 1.0
// ============================================================================
module mkio_bc_tx
  import mkio_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 16,
  parameter int GAP_CLKS         = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] cmd_word,
  input  logic        tx_inhibit,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        DO1,
  output logic        DO0
);

  state_e                    state_q, state_d;
  logic [5:0]                words_left_q, words_left_d;
  logic [4:0]                rd_addr_q, rd_addr_d;
  logic                      ser_load, ser_line, ser_half_tick, ser_word_end;
  logic [5:0]                ser_half_idx;
  logic [WORD_HALF_BITS-1:0] ser_word;
  logic                      word_active;

  assign word_active = (state_q == ST_SYNC) || (state_q == ST_BITS) || (state_q == ST_PARITY);

  mkio_manchester_ser #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .en_i       (word_active),
    .load_i     (ser_load),
    .word_i     (ser_word),
    .line_o     (ser_line),
    .half_idx_o (ser_half_idx),
    .half_tick_o(ser_half_tick),
    .word_end_o (ser_word_end)
  );

`ifdef MKIO_BC_MIN_GAP_EN
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end

  assign busy = word_active || (state_q == ST_END) || (state_q == ST_GAP);
`else
  logic gap_unused;
  assign gap_unused = (GAP_CLKS != 0);
  assign busy       = word_active;
`endif

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    rd_addr_d    = rd_addr_q;
    ser_load     = 1'b0;
    ser_word     = encode_word(SYNC_DATA, rd_data);
`ifdef MKIO_BC_MIN_GAP_EN
    gap_d        = gap_q;
`endif
    if (tx_inhibit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_SYNC;
            rd_addr_d = 5'd0;
            ser_load  = 1'b1;
            ser_word  = encode_word(SYNC_CMD, cmd_word);
            // RT-transmit commands carry no data words; WC of 0 encodes 32.
            if (cmd_word[TR_BIT])
              words_left_d = 6'd0;
            else if (cmd_word[WC_MSB:WC_LSB] == 5'd0)
              words_left_d = 6'd32;
            else
              words_left_d = {1'b0, cmd_word[WC_MSB:WC_LSB]};
          end
        end
        ST_SYNC:   if (ser_half_tick && ser_half_idx == 6'd5)  state_d = ST_BITS;
        ST_BITS:   if (ser_half_tick && ser_half_idx == 6'd37) state_d = ST_PARITY;
        ST_PARITY: begin
          if (ser_word_end) begin
            if (words_left_q != 6'd0) begin
              state_d      = ST_SYNC;
              ser_load     = 1'b1;
              words_left_d = words_left_q - 6'd1;
              rd_addr_d    = rd_addr_q + 5'd1;
            end else begin
              state_d = ST_END;
            end
          end
        end
        ST_END: begin
`ifdef MKIO_BC_MIN_GAP_EN
          state_d = ST_GAP;
          gap_d   = '0;
`else
          state_d = ST_IDLE;
`endif
        end
`ifdef MKIO_BC_MIN_GAP_EN
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CLKS - 1)) state_d = ST_IDLE;
          else                               gap_d   = gap_q + 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign done    = (state_q == ST_END);
  assign DO1     = word_active & ser_line;
  assign DO0     = word_active & ~ser_line;

endmodule
`default_nettype wire

// File: tb/tb_mkio_bc_tx.sv
`default_nettype none
// ============================================================================
// tb_mkio_bc_tx : directed self-checking bench; decodes the line half-bit by
//                 half-bit and compares against hand-computed words.
// Revision      : 1.0
// ============================================================================
module tb_mkio_bc_tx;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] cmd_word;
  logic        tx_inhibit;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy, done, DO1, DO0;

  logic [15:0] mem [0:31];
  assign rd_data = mem[rd_addr];

  int checks = 0;
  int passed = 0;

  logic [15:0] cap_word [0:32];
  logic [5:0]  cap_sync [0:32];
  logic [1:0]  cap_par  [0:32];
  logic [4:0]  cap_addr [0:32];
  int cap_line_bad, cap_busy_bad, cap_done_bad, cap_jitter, cap_manch_bad;

  mkio_bc_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd_word  (cmd_word),
    .tx_inhibit(tx_inhibit),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .DO1       (DO1),
    .DO0       (DO0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_par(input logic [15:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {p, ~p};
  endfunction

  task automatic send_start(input logic [15:0] cmd);
    @(negedge clk);
    cmd_word = cmd;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Called in the first cycle after the accepting edge; returns in the done cycle.
  task automatic capture(input int nwords);
    logic [39:0] hb;
    logic        first;
    hb = '0; first = 1'b0;
    cap_line_bad = 0; cap_busy_bad = 0; cap_done_bad = 0; cap_jitter = 0; cap_manch_bad = 0;
    for (int c = 0; c < nwords * 640; c++) begin
      int w;
      int ph;
      int k;
      w = c / 640; ph = c % 640; k = ph % 16;
      if (DO0 !== ~DO1) cap_line_bad++;
      if (busy !== 1'b1) cap_busy_bad++;
      if (done !== 1'b0) cap_done_bad++;
      if (k == 0) first = DO1;
      else if (DO1 !== first) cap_jitter++;
      if (k == 8) hb[39 - ph / 16] = DO1;
      if (ph == 320) cap_addr[w] = rd_addr;
      if (ph == 639) begin
        cap_sync[w] = hb[39:34];
        cap_par[w]  = hb[1:0];
        for (int b = 0; b < 16; b++) begin
          cap_word[w][15 - b] = hb[33 - 2*b];
          if (hb[32 - 2*b] !== ~hb[33 - 2*b]) cap_manch_bad++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (DO1 !== 1'b0 || DO0 !== 1'b0) $display("FAIL reset_line: DO1=%b DO0=%b want 0 0", DO1, DO0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else passed++;
    checks++; if (busy !== 1'b0 || DO1 !== 1'b0) $display("FAIL post_reset_idle: busy=%b DO1=%b want 0 0", busy, DO1); else passed++;
  endtask

  task automatic test_receive();
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    send_start(16'h0847);
    checks++; if (busy !== 1'b1 || DO1 !== 1'b1 || DO0 !== 1'b0)
      $display("FAIL rx_first_cycle: busy=%b DO1=%b DO0=%b want 1 1 0", busy, DO1, DO0); else passed++;
    capture(8);
    checks++; if (cap_sync[0] !== 6'b111000) $display("FAIL rx_cmd_sync: got %b want 111000", cap_sync[0]); else passed++;
    checks++; if (cap_word[0][15:11] !== 5'd1 || cap_word[0][10] !== 1'b0 || cap_word[0][9:5] !== 5'd2 || cap_word[0][4:0] !== 5'd7)
      $display("FAIL rx_cmd_fields: got %h want 0847", cap_word[0]); else passed++;
    checks++; if (cap_par[0] !== exp_par(16'h0847)) $display("FAIL rx_cmd_parity: got %b want %b", cap_par[0], exp_par(16'h0847)); else passed++;
    for (int w = 1; w < 8; w++) begin
      checks++; if (cap_word[w] !== mem[w-1]) $display("FAIL rx_data%0d: got %h want %h", w, cap_word[w], mem[w-1]); else passed++;
      checks++; if (cap_sync[w] !== 6'b000111 || cap_par[w] !== exp_par(mem[w-1]))
        $display("FAIL rx_sync_par%0d: got %b/%b want 000111/%b", w, cap_sync[w], cap_par[w], exp_par(mem[w-1])); else passed++;
    end
    for (int w = 0; w < 8; w++) begin
      checks++; if (cap_addr[w] !== 5'(w)) $display("FAIL rx_rd_addr%0d: got %0d want %0d", w, cap_addr[w], w); else passed++;
    end
    checks++; if (cap_line_bad !== 0 || cap_manch_bad !== 0) $display("FAIL rx_line_complement: got %0d/%0d bad want 0", cap_line_bad, cap_manch_bad); else passed++;
    checks++; if (cap_jitter !== 0) $display("FAIL rx_half_bit_edges: got %0d bad want 0", cap_jitter); else passed++;
    checks++; if (cap_busy_bad !== 0 || cap_done_bad !== 0) $display("FAIL rx_busy_done_during: got %0d/%0d want 0/0", cap_busy_bad, cap_done_bad); else passed++;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || DO1 !== 1'b0 || DO0 !== 1'b0)
      $display("FAIL rx_done_cycle: done=%b busy=%b DO1=%b DO0=%b want 1 0 0 0", done, busy, DO1, DO0); else passed++;
    checks++; if (rd_addr !== 5'd7) $display("FAIL rx_final_addr: got %0d want 7", rd_addr); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL rx_done_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_transmit_cmd();
    send_start(16'h0C84);
    capture(1);
    checks++; if (cap_word[0] !== 16'h0C84 || cap_sync[0] !== 6'b111000)
      $display("FAIL tx_cmd_word: got %h/%b want 0c84/111000", cap_word[0], cap_sync[0]); else passed++;
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL tx_done_t641: done=%b busy=%b want 1 0", done, busy); else passed++;
    checks++; if (rd_addr !== 5'd0) $display("FAIL tx_rd_addr: got %0d want 0", rd_addr); else passed++;
    checks++; if (cap_busy_bad !== 0 || cap_done_bad !== 0) $display("FAIL tx_busy_done_during: got %0d/%0d want 0/0", cap_busy_bad, cap_done_bad); else passed++;
  endtask

  task automatic test_wc0();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    send_start(16'h1820);
    capture(33);
    for (int w = 1; w < 33; w++) if (cap_word[w] !== mem[w-1] || cap_sync[w] !== 6'b000111) bad++;
    checks++; if (bad !== 0) $display("FAIL wc0_data_words: got %0d wrong want 0", bad); else passed++;
    checks++; if (cap_word[32] !== mem[31]) $display("FAIL wc0_last_word: got %h want %h", cap_word[32], mem[31]); else passed++;
    checks++; if (cap_addr[31] !== 5'd31 || cap_addr[32] !== 5'd0)
      $display("FAIL wc0_addr_wrap: got %0d,%0d want 31,0", cap_addr[31], cap_addr[32]); else passed++;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rd_addr !== 5'd0)
      $display("FAIL wc0_done: done=%b busy=%b rd_addr=%0d want 1 0 0", done, busy, rd_addr); else passed++;
    checks++; if (cap_jitter !== 0 || cap_busy_bad !== 0) $display("FAIL wc0_contiguity: got %0d/%0d want 0/0", cap_jitter, cap_busy_bad); else passed++;
  endtask

  task automatic test_parity_sync();
    mem[0] = 16'h0000;
    mem[1] = 16'h0001;
    send_start(16'h2862);
    capture(3);
    checks++; if (cap_sync[1] !== 6'b000111 || cap_sync[2] !== 6'b000111)
      $display("FAIL ps_data_sync: got %b,%b want 000111", cap_sync[1], cap_sync[2]); else passed++;
    checks++; if (cap_par[1] !== 2'b10) $display("FAIL ps_par_0000: got %b want 10", cap_par[1]); else passed++;
    checks++; if (cap_par[2] !== 2'b01) $display("FAIL ps_par_0001: got %b want 01", cap_par[2]); else passed++;
    checks++; if (cap_par[0] !== 2'b01) $display("FAIL ps_par_cmd2862: got %b want 01", cap_par[0]); else passed++;
    checks++; if (cap_word[1] !== 16'h0000 || cap_word[2] !== 16'h0001)
      $display("FAIL ps_data: got %h,%h want 0000,0001", cap_word[1], cap_word[2]); else passed++;
    checks++; if (cap_line_bad !== 0 || cap_manch_bad !== 0) $display("FAIL ps_do0_not_do1: got %0d/%0d want 0", cap_line_bad, cap_manch_bad); else passed++;
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    send_start(16'h1025);
    repeat (3 * 640 + 100) @(negedge clk);
    checks++; if (busy !== 1'b1 || (DO1 | DO0) !== 1'b1) $display("FAIL ab_active: busy=%b DO1|DO0=%b want 1 1", busy, DO1 | DO0); else passed++;
    tx_inhibit = 1'b1;
    @(negedge clk);
    checks++; if (DO1 !== 1'b0 || DO0 !== 1'b0 || busy !== 1'b0)
      $display("FAIL ab_inhibit_next: DO1=%b DO0=%b busy=%b want 0 0 0", DO1, DO0, busy); else passed++;
    cmd_word = 16'h0847;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    checks++; if (busy !== 1'b0 || DO1 !== 1'b0) $display("FAIL ab_start_inhibited: busy=%b DO1=%b want 0 0", busy, DO1); else passed++;
    tx_inhibit = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || DO1 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL ab_no_done: got %0d active cycles want 0", bad); else passed++;
  endtask

  task automatic test_busy_start();
    int bad;
    bad = 0;
    mem[0] = 16'hA5C3;
    send_start(16'h0801);
    fork
      capture(2);
      begin
        repeat (300) @(negedge clk);
        cmd_word = 16'h0C84;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
      end
    join
    checks++; if (cap_word[0] !== 16'h0801 || cap_word[1] !== 16'hA5C3)
      $display("FAIL bs_stream: got %h,%h want 0801,a5c3", cap_word[0], cap_word[1]); else passed++;
    checks++; if (done !== 1'b1 || cap_busy_bad !== 0 || cap_done_bad !== 0)
      $display("FAIL bs_done: done=%b busy_bad=%0d done_bad=%0d want 1 0 0", done, cap_busy_bad, cap_done_bad); else passed++;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || DO1 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL bs_not_queued: got %0d busy cycles want 0", bad); else passed++;
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    send_start(16'h0847);
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (DO1 !== 1'b0 || DO0 !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_async: DO1=%b DO0=%b busy=%b done=%b want 0 0 0 0", DO1, DO0, busy, done); else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rst_no_done: got %0d active cycles want 0", bad); else passed++;
  endtask

  task automatic test_back_to_back();
    send_start(16'h0C84);
    capture(1);
    checks++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else passed++;
`ifdef MKIO_BC_MIN_GAP_EN
    begin
      int waited;
      waited = 0;
      send_start(16'h0C84);
      checks++; if (busy !== 1'b1 || DO1 !== 1'b0 || DO0 !== 1'b0)
        $display("FAIL b2b_gap_ignored: busy=%b DO1=%b DO0=%b want 1 0 0", busy, DO1, DO0); else passed++;
      while (busy === 1'b1 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      checks++; if (busy !== 1'b0) $display("FAIL b2b_gap_timeout: busy=%b want 0", busy); else passed++;
    end
`endif
    send_start(16'h0C84);
    checks++; if (busy !== 1'b1 || DO1 !== 1'b1) $display("FAIL b2b_accept: busy=%b DO1=%b want 1 1", busy, DO1); else passed++;
    capture(1);
    checks++; if (cap_word[0] !== 16'h0C84 || done !== 1'b1)
      $display("FAIL b2b_second: word=%h done=%b want 0c84 1", cap_word[0], done); else passed++;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    cmd_word   = 16'h0000;
    tx_inhibit = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    test_reset();
    test_receive();
    test_transmit_cmd();
    test_wc0();
    test_parity_sync();
    test_abort();
    test_busy_start();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mkio_bc_tx.md
# mkio_bc_tx

Bus-controller-side MIL-STD-1553B message transmitter. It is the initiator counterpart of the `mkio` remote-terminal receive path. The block takes a command word and a local data buffer and serialises a complete BC→RT message onto one bus channel as Manchester II bi-phase with command/data sync, 16 data bits and odd parity. It sits between the BC message scheduler and the channel line driver, and shares the 32 MHz system clock with `mkio`.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, 16: clocks per Manchester half-bit. The default gives 500 ns at 32 MHz, i.e. 1 Mbit/s.
- `GAP_CLKS`, 128: minimum inter-message gap in clocks. Used only with `MKIO_BC_MIN_GAP_EN`.

Ports:
- `clk`  in  1  system clock, 32 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to send a message. Sampled only in IDLE.
- `cmd_word`  in  16  command word: [15:11] RT address, [10] T/R, [9:5] subaddress, [4:0] word count (0 = 32). Latched on accepted `start`.
- `tx_inhibit`  in  1  abort/inhibit. While high, the line is idle and `start` is ignored.
- `rd_addr`  out  5  data-buffer read address.
- `rd_data`  in  16  data-buffer word at `rd_addr`. Must be stable within 2 cycles of any `rd_addr` change.
- `busy`  out  1  high while a message (or gap) is in progress.
- `done`  out  1  one-cycle pulse on normal message completion.
- `DO1`  out  1  positive line output.
- `DO0`  out  1  negative line output.

## Operation
- Reset values: `DO1`=`DO0`=0, `busy`=0, `done`=0, `rd_addr`=0, FSM=IDLE.
- FSM states: IDLE → SYNC → BITS → PARITY → (SYNC of next word | END) → IDLE. With `MKIO_BC_MIN_GAP_EN` the sequence is END → GAP → IDLE.
- IDLE:
  - If `start`=1 and `tx_inhibit`=0, latch `cmd_word` and set `rd_addr`=0.
  - Load the command word into the 40-half-bit shifter.
  - Go to SYNC.
- Message length:
  - If T/R=1 (RT transmit), send the command word only.
  - Otherwise send the command word, then N data words, where N = `cmd_word[4:0]` and 0 means 32.
- Word encoding, 40 half-bits, MSB first:
  - Command sync half-bits 111000; data sync half-bits 000111.
  - Each data bit b is sent as half-bits (b, ~b), bit 15 first.
  - Parity bit p = ~^data (odd parity over 16+1 bits), sent as (p, ~p).
- Line drive: during a word, `DO0` = ~`DO1`. Between messages both outputs are 0.
- Data fetch:
  - At each word load, the shifter takes `rd_data`; `rd_addr` then increments to point at the next word.
  - Data word k is read from address k−1. `rd_addr` wraps 31→0 after a 32-word message.
- Word contiguity: words within a message are back-to-back, with no dead half-bit.
- `start` while `busy`: ignored and not queued.
- `tx_inhibit` rising at any point:
  - Next cycle, `DO1`=`DO0`=0, `busy`=0, FSM=IDLE.
  - `done` does not pulse and the message is dropped.
- `reset` mid-message: outputs go to 0 immediately (asynchronous). No `done`.

## Timing
- Word time is 40×`CLK_PER_HALF_BIT` = 640 clocks.
- `start` accepted at cycle t:
  - `busy`=1 and `DO1`=1 (first sync half-bit) from t+1.
  - Message occupies cycles t+1 … t+(N+1)·640.
- Completion: at t+(N+1)·640+1, `DO1`=`DO0`=0 and `done`=1 for one cycle. `busy`=0 the same cycle (or after the gap, see Configuration).
- Half-bit edges fall exactly every `CLK_PER_HALF_BIT` clocks, with no jitter across word boundaries.
- Data-word `rd_data` is sampled at the last clock of the preceding word.

## Configuration
- `MKIO_BC_MIN_GAP_EN` defined:
  - After the final word, `done` pulses as normal.
  - `busy` stays high for a further `GAP_CLKS` cycles (GAP state, line idle).
  - `start` in GAP is ignored, which enforces the 4 µs inter-message gap.
- `MKIO_BC_MIN_GAP_EN` undefined: no GAP state; `busy` falls together with `done`.

## Structure
- Package `mkio_pkg`:
  - `SYNC_CMD`=6'b111000, `SYNC_DATA`=6'b000111.
  - Command-word field localparams (RTA, TR, SA, WC bit positions).
  - FSM state enum typedef.
- Sub-module `mkio_manchester_ser`:
  - Half-bit timer plus 40-bit shifter with `load` and `word_end` strobes.
  - The top level holds only the FSM, word/address counters and parity generation.

## Test plan
- Scenario 1, receive message:
  - Stimulus: `cmd_word`={5'd1,1'b0,5'd2,5'd7}, buffer[0..6] random.
  - Response: 8 words over 5120 cycles. Line decode gives command RTA=1 SA=2 WC=7, then data = buffer[0..6]. `rd_addr` steps 0..7. `done` at t+5121.
- Scenario 2, transmit command:
  - Stimulus: `cmd_word`={5'd1,1'b1,5'd4,5'd4}.
  - Response: command word only over 640 cycles. `done` at t+641. `rd_addr` unchanged at 0.
- Scenario 3, word count 0:
  - Stimulus: WC=0, T/R=0.
  - Response: 33 words over 21120 cycles. `rd_addr` wraps back to 0. Last data word = buffer[31].
- Scenario 4, parity and sync:
  - Stimulus: data 16'h0000, then 16'h0001.
  - Response: sync 000111 on both words. Parity half-bits are 1,0 for 16'h0000 and 0,1 for 16'h0001. `DO0`==~`DO1` throughout each word.
- Scenario 5, abort and busy:
  - Stimulus: `tx_inhibit` pulsed during data word 3; separately, `start` pulsed while `busy`.
  - Response: on inhibit, line goes to 0 the next cycle, `busy`=0 and no `done`. The `start` while `busy` has no effect on the output stream.
- Scenario 6, reset and gap:
  - Stimulus: `reset` asserted mid-word, then a back-to-back `start`.
  - Response: on reset, outputs are 0 asynchronously. With `MKIO_BC_MIN_GAP_EN`, a `start` within 128 cycles after `done` is ignored.
